// File: rtl/servo_pkg.sv
// Shared types and defaults for the servo command filter.
package servo_pkg;

  localparam int W         = 15;
  localparam int RESET_POS = 16384;

  typedef enum logic {
    PRIME = 1'b0,
    RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/moving_avg.sv
// Power-of-two moving average over a circular buffer; the first accepted
// sample (i_prime high) fills the whole window so the average starts settled.
module moving_avg #(
  parameter int W        = servo_pkg::W,
  parameter int AVG_LOG2 = 3
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_sample,
  input  logic         i_accept,
  input  logic         i_prime,
  output logic [W-1:0] o_avg
);
  import servo_pkg::*;

  localparam int N  = 1 << AVG_LOG2;
  localparam int SW = W + AVG_LOG2;

  logic [W-1:0]        r_buf [N];
  logic [AVG_LOG2-1:0] r_ptr;
  logic [SW-1:0]       r_sum;
  logic [W-1:0]        r_avg;
  logic [SW-1:0]       w_sum_next;

  always_comb begin
    w_sum_next = r_sum;
    if (i_prime) w_sum_next = {i_sample, AVG_LOG2'(0)};
    else         w_sum_next = r_sum - SW'(r_buf[r_ptr]) + SW'(i_sample);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= '0;
      r_sum <= '0;
      r_avg <= '0;
    end else if (i_accept) begin
      r_sum <= w_sum_next;
      r_avg <= w_sum_next[SW-1:AVG_LOG2];
      if (!i_prime) r_ptr <= r_ptr + AVG_LOG2'(1);
    end
  end

  // Buffer needs no reset: priming overwrites every entry before it is read.
  always_ff @(posedge i_clk) begin
    if (i_accept) begin
      if (i_prime) begin
        for (int i = 0; i < N; i++) r_buf[i] <= i_sample;
      end else begin
        r_buf[r_ptr] <= i_sample;
      end
    end
  end

  assign o_avg = r_avg;

endmodule

// File: rtl/servo_cmd_filter.sv
// Averages ADC samples and walks the servo command toward the average.
// SERVO_SLEW_LIMIT_EN enables the tick-based slew limiter; otherwise pos tracks avg.
module servo_cmd_filter #(
  parameter int W         = servo_pkg::W,
  parameter int AVG_LOG2  = 3,
  parameter int STEP      = 64,
  parameter int TICK_DIV  = 500000,
  parameter int RESET_POS = servo_pkg::RESET_POS
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_sample,
  input  logic         i_sample_valid,
  input  logic         i_hold,
  output logic [W-1:0] o_avg,
  output logic [W-1:0] o_pos,
  output logic         o_settled
);
  import servo_pkg::*;

  state_t       r_state;
  logic         w_accept;
  logic         w_prime;
  logic [W-1:0] w_avg;

  assign w_accept = i_sample_valid & ~i_hold;
  assign w_prime  = (r_state == PRIME);

  moving_avg #(.W(W), .AVG_LOG2(AVG_LOG2)) u_avg (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_sample (i_sample),
    .i_accept (w_accept),
    .i_prime  (w_prime),
    .o_avg    (w_avg)
  );

  assign o_avg = w_avg;

`ifdef SERVO_SLEW_LIMIT_EN
  localparam int         CW     = $clog2(TICK_DIV + 1);
  localparam logic [W:0] STEP_V = (W+1)'(STEP);
  localparam logic [W-1:0] STEP_W = W'(STEP);

  logic [CW-1:0]   r_tick_cnt;
  logic            w_tick;
  logic [W-1:0]    r_pos;
  logic            r_settled;
  logic signed [W:0] w_diff;
  logic [W:0]      w_mag;
  logic [W-1:0]    w_pos_next;

  assign w_tick = (r_tick_cnt == CW'(TICK_DIV - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_tick_cnt <= '0;
    else          r_tick_cnt <= w_tick ? '0 : r_tick_cnt + CW'(1);
  end

  assign w_diff = $signed({1'b0, w_avg}) - $signed({1'b0, r_pos});
  assign w_mag  = w_diff[W] ? $unsigned(-w_diff) : $unsigned(w_diff);

  always_comb begin
    w_pos_next = w_avg;
    if (w_mag > STEP_V) w_pos_next = w_diff[W] ? r_pos - STEP_W : r_pos + STEP_W;
  end

  // Tick uses the pre-update avg; a sample landing on the same edge counts next tick.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= PRIME;
      r_pos     <= W'(RESET_POS);
      r_settled <= 1'b0;
    end else begin
      if (w_accept) r_state <= RUN;
      if (w_tick && r_state == RUN && !i_hold) begin
        r_pos     <= w_pos_next;
        r_settled <= (w_pos_next == w_avg);
      end
    end
  end

  assign o_pos     = r_pos;
  assign o_settled = r_settled;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = STEP[0] ^ TICK_DIV[0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)      r_state <= PRIME;
    else if (w_accept) r_state <= RUN;
  end

  // avg only moves on accepted samples, so hold freezes pos for free.
  assign o_pos     = (r_state == RUN) ? w_avg : W'(RESET_POS);
  assign o_settled = (r_state == RUN);
`endif

endmodule

// File: tb/tb_servo_cmd_filter.sv
// Directed bench for servo_cmd_filter; covers both SERVO_SLEW_LIMIT_EN builds.
module tb_servo_cmd_filter;
  localparam int W  = 15;
  localparam int TD = 10;
  localparam int RP = 16384;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] sample = '0;
  logic         sample_valid = 1'b0;
  logic         hold = 1'b0;
  logic [W-1:0] avg;
  logic [W-1:0] pos;
  logic         settled;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  servo_cmd_filter #(.W(W), .AVG_LOG2(3), .STEP(64), .TICK_DIV(TD), .RESET_POS(RP)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_sample       (sample),
    .i_sample_valid (sample_valid),
    .i_hold         (hold),
    .o_avg          (avg),
    .o_pos          (pos),
    .o_settled      (settled)
  );

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Presents one strobe; returns at the negedge after the sampling edge.
  task automatic strobe(input logic [W-1:0] v);
    @(negedge clk);
    sample = v;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (avg !== 15'd0) begin bad++; $display("FAIL reset_avg got=%0d want=0", avg); end
    total++; if (pos !== 15'(RP)) begin bad++; $display("FAIL reset_pos got=%0d want=%0d", pos, RP); end
    total++; if (settled !== 1'b0) begin bad++; $display("FAIL reset_settled got=%0b want=0", settled); end
  endtask

  task automatic test_hold_in_prime();
    hold = 1'b1;
    strobe(15'd20000);
    hold = 1'b0;
    total++; if (avg !== 15'd0) begin bad++; $display("FAIL hold_prime_avg got=%0d want=0", avg); end
    total++; if (pos !== 15'(RP)) begin bad++; $display("FAIL hold_prime_pos got=%0d want=%0d", pos, RP); end
  endtask

`ifdef SERVO_SLEW_LIMIT_EN
  task automatic wait_change(input logic [W-1:0] prev, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (pos == prev && n < 4*TD);
  endtask

  task automatic test_slew_prime();
    int n;
    int exp_pos;
    do_reset();
    strobe(15'd20000);
    total++; if (avg !== 15'd20000) begin bad++; $display("FAIL prime_avg got=%0d want=20000", avg); end
    total++; if (pos !== 15'(RP)) begin bad++; $display("FAIL prime_pos_pre_tick got=%0d want=%0d", pos, RP); end
    for (int k = 1; k <= 57; k++) begin
      wait_change(pos, n);
      exp_pos = (RP + 64*k > 20000) ? 20000 : RP + 64*k;
      total++;
      if (n >= 4*TD) begin bad++; $display("FAIL slew_timeout tick=%0d pos=%0d", k, pos); end
      else if (n != ((k == 1) ? TD-2 : TD)) begin bad++; $display("FAIL tick_spacing tick=%0d got=%0d want=%0d", k, n, (k == 1) ? TD-2 : TD); end
      total++; if (pos !== 15'(exp_pos)) begin bad++; $display("FAIL slew_pos tick=%0d got=%0d want=%0d", k, pos, exp_pos); end
      total++; if (settled !== (k == 57)) begin bad++; $display("FAIL slew_settled tick=%0d got=%0b want=%0b", k, settled, k == 57); end
    end
    repeat (3*TD) @(negedge clk);
    total++; if (pos !== 15'd20000 || settled !== 1'b1) begin bad++; $display("FAIL settled_stays pos=%0d settled=%0b want=20000/1", pos, settled); end
  endtask

  task automatic test_hold_collision();
    int n;
    hold = 1'b1;
    strobe(15'd30000);
    total++; if (avg !== 15'd20000) begin bad++; $display("FAIL hold_avg got=%0d want=20000", avg); end
    repeat (3*TD) @(negedge clk);
    total++; if (pos !== 15'd20000) begin bad++; $display("FAIL hold_pos got=%0d want=20000", pos); end
    hold = 1'b0;
    strobe(15'd30000);
    total++; if (avg !== 15'd21250) begin bad++; $display("FAIL resume_avg got=%0d want=21250", avg); end
    wait_change(pos, n);
    total++; if (pos !== 15'd20064 || settled !== 1'b0) begin bad++; $display("FAIL resume_pos got=%0d/%0b want=20064/0", pos, settled); end
    // Next update edge is TD cycles later; put a sample on that same edge.
    repeat (TD-2) @(negedge clk);
    strobe(15'd0);
    total++; if (avg !== 15'd18750) begin bad++; $display("FAIL collide_avg got=%0d want=18750", avg); end
    total++; if (pos !== 15'd20128) begin bad++; $display("FAIL collide_old_avg got=%0d want=20128", pos); end
    wait_change(pos, n);
    total++; if (pos !== 15'd20064) begin bad++; $display("FAIL collide_new_avg got=%0d want=20064", pos); end
  endtask

  task automatic test_small_delta_and_reset();
    int n;
    do_reset();
    strobe(15'd10000);
    n = 0;
    while (!(pos == 15'd10000 && settled) && n < 120*TD) begin @(negedge clk); n++; end
    total++; if (pos !== 15'd10000 || settled !== 1'b1) begin bad++; $display("FAIL reach_10000 pos=%0d settled=%0b", pos, settled); end
    strobe(15'd10240);
    total++; if (avg !== 15'd10030) begin bad++; $display("FAIL small_avg got=%0d want=10030", avg); end
    wait_change(pos, n);
    total++; if (pos !== 15'd10030 || settled !== 1'b1) begin bad++; $display("FAIL small_delta got=%0d/%0b want=10030/1", pos, settled); end
    strobe(15'd32000);
    total++; if (avg !== 15'd12780) begin bad++; $display("FAIL big_avg got=%0d want=12780", avg); end
    wait_change(pos, n);
    total++; if (pos !== 15'd10094) begin bad++; $display("FAIL big_step got=%0d want=10094", pos); end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if (avg !== 15'd0 || pos !== 15'(RP) || settled !== 1'b0) begin bad++; $display("FAIL mid_reset got=%0d/%0d/%0b want=0/%0d/0", avg, pos, settled, RP); end
    @(negedge clk);
    rst_n = 1'b1;
    strobe(15'd500);
    total++; if (avg !== 15'd500 || pos !== 15'(RP)) begin bad++; $display("FAIL reprime got=%0d/%0d want=500/%0d", avg, pos, RP); end
  endtask
`else
  task automatic test_prime();
    strobe(15'd20000);
    total++; if (avg !== 15'd20000) begin bad++; $display("FAIL prime_avg got=%0d want=20000", avg); end
    total++; if (pos !== 15'd20000) begin bad++; $display("FAIL prime_pos got=%0d want=20000", pos); end
    total++; if (settled !== 1'b1) begin bad++; $display("FAIL prime_settled got=%0b want=1", settled); end
  endtask

  task automatic test_average_wrap();
    int e;
    do_reset();
    strobe(15'd0);
    total++; if (avg !== 15'd0 || pos !== 15'd0) begin bad++; $display("FAIL prime0 got=%0d/%0d want=0/0", avg, pos); end
    for (int k = 1; k <= 8; k++) begin
      strobe(15'd8000);
      e = 1000*k;
      total++; if (avg !== 15'(e)) begin bad++; $display("FAIL rise_avg k=%0d got=%0d want=%0d", k, avg, e); end
      total++; if (pos !== 15'(e)) begin bad++; $display("FAIL rise_pos k=%0d got=%0d want=%0d", k, pos, e); end
    end
    for (int k = 1; k <= 8; k++) begin
      strobe(15'd0);
      e = 8000 - 1000*k;
      total++; if (avg !== 15'(e)) begin bad++; $display("FAIL fall_avg k=%0d got=%0d want=%0d", k, avg, e); end
    end
  endtask

  task automatic test_hold();
    hold = 1'b1;
    strobe(15'd30000);
    total++; if (avg !== 15'd0 || pos !== 15'd0) begin bad++; $display("FAIL hold got=%0d/%0d want=0/0", avg, pos); end
    hold = 1'b0;
    strobe(15'd30000);
    total++; if (avg !== 15'd3750 || pos !== 15'd3750) begin bad++; $display("FAIL resume got=%0d/%0d want=3750/3750", avg, pos); end
    strobe(15'd7);
    total++; if (avg !== 15'd3750) begin bad++; $display("FAIL truncate got=%0d want=3750", avg); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if (avg !== 15'd0 || pos !== 15'(RP) || settled !== 1'b0) begin bad++; $display("FAIL mid_reset got=%0d/%0d/%0b want=0/%0d/0", avg, pos, settled, RP); end
    @(negedge clk);
    rst_n = 1'b1;
    strobe(15'd500);
    total++; if (avg !== 15'd500 || pos !== 15'd500 || settled !== 1'b1) begin bad++; $display("FAIL reprime got=%0d/%0d/%0b want=500/500/1", avg, pos, settled); end
  endtask
`endif

  initial begin
    test_reset();
    test_hold_in_prime();
`ifdef SERVO_SLEW_LIMIT_EN
    test_slew_prime();
    test_hold_collision();
    test_small_delta_and_reset();
`else
    test_prime();
    test_average_wrap();
    test_hold();
    test_reset_mid();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
